arbitro_rr: RTL
===============

# arbitro_rr

Sequential round-robin arbiter for four requesters sharing one resource. A grant is held while its owner keeps requesting, up to a programmable hold limit, so no requester can starve the others. It sits between the four requesting masters and the shared resource's select mux. It keeps the `grant` / `grant_num` / `available` output convention of the existing combinational arbiter.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. Legal range is 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req` input 4: request lines, bit i from requester i, level-sensitive.
- `req_mask` input 4: per-requester disable. A bit at 1 ignores that requester. Sampled synchronously.
- `grant` output 4: registered one-hot grant, or 0 when no owner.
- `grant_num` output 2: registered index of the current owner. Holds its last value when `grant` is 0.
- `available` output 1: high when `grant` is 0.
- `expired` output 1: one-cycle pulse on a forced release at `MAX_HOLD`.

## Operation
- Effective request: `ereq = req & ~req_mask`.
- Reset values (asynchronous, `rst_n` low):
  - state IDLE, `grant` 0, `grant_num` 0, `available` 1, `expired` 0
  - `hold_cnt` 0, `last` 3 (so the first search starts at requester 0)
- Arbitration order: search `last+1`, `last+2`, `last+3`, `last`, modulo 4. Pick the first index with its `ereq` bit set.
- State machine, two states:
  - **IDLE**:
    - If `ereq` is nonzero: at the edge, set `grant` to the one-hot of the winner, `grant_num` to the winner, `last` to the winner, `hold_cnt` to 1, and go to BUSY.
    - Otherwise stay in IDLE with `grant` 0.
  - **BUSY** (owner o = `grant_num`), checked in priority order:
    - `ereq[o]` is 0: release. `grant` goes to 0, go to IDLE, `expired` stays 0.
    - `hold_cnt == MAX_HOLD`: forced release. `grant` goes to 0, `expired` goes to 1 for one cycle, go to IDLE.
    - Otherwise: `hold_cnt` increments and `grant` is unchanged.
- Every release leaves exactly one dead cycle (`grant` 0) before the next grant. This is the mandatory bus turnaround.
- A force-released requester that is still requesting competes normally. Because `last` equals its index, it has lowest priority.
- A lone continuous requester therefore sees `MAX_HOLD` cycles granted, then 1 cycle off, repeating.
- Masking the current owner mid-grant counts as a deassert: normal release, no `expired`.
- Changes on `req` for non-owners during BUSY have no effect until the next IDLE cycle.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`. It never exceeds `MAX_HOLD` and never wraps.
- `available` is derived combinationally from the registered `grant` (no extra latency).
- `expired` is registered and is 1 only in the dead cycle that follows a forced release.

## Timing
- Request to grant: `req` sampled high at edge t gives `grant` valid after edge t. This is 1-cycle latency from IDLE.
- Release: owner `req` sampled low at edge k gives `grant` 0 after edge k. The earliest next grant appears after edge k+1.
- Minimum grant length is 1 cycle; maximum is `MAX_HOLD` cycles.
- An asynchronous reset mid-grant drops `grant` immediately with no `expired` pulse. After `rst_n` rises, arbitration restarts from requester 0.
- No combinational path from `req` to any output.

## Structure
- Package `arbitro_pkg` holds:
  - `NUM_REQ = 4`
  - typedef `arb_state_t` enum {IDLE, BUSY}
  - typedef `req_vec_t` logic [3:0]
- Sub-module `arbitro_rr_pick`: combinational, takes inputs `ereq` and `last` and produces `pick_valid` and `pick_num` (2-bit). Implement it by rotating `ereq` right by `last+1`, applying a fixed priority encode (lowest index wins), and adding the offset back modulo 4.
- The top level holds the FSM, `hold_cnt`, the `last` register and the output registers.

## Test plan
- Reset: assert `rst_n`=0 with `req`=4'b1111. Required: `grant`=0, `grant_num`=0, `available`=1, `expired`=0. Release reset: first grant is 4'b0001.
- Saturation, `MAX_HOLD`=8, `req`=4'b1111 held: grants go to requesters 0,1,2,3,0, each for 8 cycles separated by 1 dead cycle. `expired` pulses in each dead cycle.
- Single-cycle request `req`=4'b0100 for one cycle: `grant`=4'b0100 for exactly 1 cycle, then 0. `grant_num` holds 2'b10. `expired` stays 0.
- With `last`=1, `req`=4'b1010 arriving together: `grant`=4'b1000 and `grant_num`=2'b11. After release, requester 1 is granted.
- Owner 2 is granted, then `req_mask`=4'b0100 is set on cycle 3: `grant` goes to 0 after that edge with no `expired`. A pending `req`[0] is granted one cycle later.
- `rst_n` pulsed low mid-grant at `hold_cnt`=5: outputs go to reset values asynchronously. After release, requester 0 wins if it is requesting.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   NUM_REQ     : number of requesters served by the arbiter
//   arb_state_t : arbiter FSM states
//   req_vec_t   : one bit per requester
package arbitro_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/arbitro_rr_pick.sv
// Combinational round-robin winner search.
// The search starts at last+1 and wraps, so `last` has the lowest priority.
//   ereq       : effective (unmasked) request vector
//   last       : index of the previous owner
//   pick_valid : at least one effective request is present
//   pick_num   : index of the winning requester
module arbitro_rr_pick
  import arbitro_pkg::*;
(
  input  req_vec_t   ereq,
  input  logic [1:0] last,
  output logic       pick_valid,
  output logic [1:0] pick_num
);

  logic [1:0] off;
  logic [7:0] dbl;
  req_vec_t   rot;
  logic [1:0] idx;

  always_comb begin
    off        = last + 2'd1;
    // Rotate right by off: rot[j] corresponds to requester (j+off) mod 4.
    dbl        = {ereq, ereq} >> off;
    rot        = dbl[3:0];
    idx        = '0;
    pick_valid = 1'b0;
    // Descending scan so the lowest set index is the one left in idx.
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (rot[j-1]) begin
        idx        = 2'(j - 1);
        pick_valid = 1'b1;
      end
    end
    pick_num = idx + off;
  end

endmodule

// File: rtl/arbitro_rr.sv
// Sequential round-robin arbiter for four requesters with a bounded hold.
// An owner keeps the grant while it requests, for at most MAX_HOLD cycles;
// every release is followed by one dead cycle before the next grant.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request lines, bit i from requester i
//   req_mask  : per-requester disable (1 ignores the requester)
//   grant     : registered one-hot grant, 0 when no owner
//   grant_num : registered owner index, holds its value while grant is 0
//   available : high while grant is 0
//   expired   : one-cycle pulse in the dead cycle after a forced release
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] req_mask,
  output logic [3:0] grant,
  output logic [1:0] grant_num,
  output logic       available,
  output logic       expired
);

  localparam int unsigned    CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);

  arb_state_t    state_q, state_d;
  req_vec_t      ereq;
  req_vec_t      grant_d;
  logic [1:0]    num_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_cnt, cnt_d;
  logic          exp_d;
  logic          pick_valid;
  logic [1:0]    pick_num;

  assign ereq      = req & ~req_mask;
  assign available = (grant == '0);

  arbitro_rr_pick u_pick (
    .ereq       (ereq),
    .last       (last_q),
    .pick_valid (pick_valid),
    .pick_num   (pick_num)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant     <= '0;
      grant_num <= '0;
      last_q    <= 2'd3;
      hold_cnt  <= '0;
      expired   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      grant_num <= num_d;
      last_q    <= last_d;
      hold_cnt  <= cnt_d;
      expired   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    num_d   = grant_num;
    last_d  = last_q;
    cnt_d   = hold_cnt;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = req_vec_t'(1) << pick_num;
          num_d   = pick_num;
          last_d  = pick_num;
          cnt_d   = CW'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!ereq[grant_num]) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (hold_cnt == HOLD_LIM) begin
          grant_d = '0;
          cnt_d   = '0;
          exp_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = hold_cnt + CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
